// File: rtl/phase_tag_merge_fifo_pkg.sv
// Shared defaults, width helper and merged-beat layout for the phase-tag merge stage.
package phase_tag_pkg;

  localparam int TAG_W_DEF = 8;
  localparam int N_CH_DEF  = 4;

  // Never returns 0, so a 2-entry space still gets a 1-bit index.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_W_DEF = clog2_safe(N_CH_DEF);

  typedef struct packed {
    logic [CH_W_DEF-1:0]  ch;
    logic [TAG_W_DEF-1:0] tag;
  } beat_t;

endpackage

// File: rtl/tag_sync_fifo.sv
// Single-clock show-ahead FIFO holding phase tags for one detector channel.
module tag_sync_fifo
  import phase_tag_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [TAG_W-1:0]           din,
  input  logic                       rd_en,
  output logic [TAG_W-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = clog2_safe(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  // Full is judged on the pre-edge count, so a same-cycle pop never admits a write.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/phase_tag_merge_fifo.sv
// Buffers N_CH phase-detector tag streams and merges them round-robin onto one
// channel-tagged output stream, counting tags lost to per-channel overflow.
module phase_tag_merge_fifo
  import phase_tag_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 8,
  parameter int AE_THRESH = 1,
  localparam int CH_W     = clog2_safe(N_CH)
) (
  input  logic                     clk_sample,
  input  logic                     rst,
  input  logic [N_CH*TAG_W-1:0]    tag_in,
  input  logic [N_CH-1:0]          tag_valid,
  output logic [TAG_W-1:0]         out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH-1:0]          ch_full,
  output logic [N_CH-1:0]          ch_empty,
  output logic [N_CH*DROP_W-1:0]   drop_count,
  input  logic                     clear_drops,
  output logic                     almost_empty
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int TOT_W = $clog2(N_CH * DEPTH + 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [TAG_W-1:0] fifo_dout [N_CH];
  logic [CW-1:0]    fifo_cnt  [N_CH];
  logic [N_CH-1:0]  pop;
  logic             load, gnt_found;
  logic [CH_W-1:0]  gnt_idx, rr_q, rr_d;
  logic             out_valid_q;
  logic [TAG_W-1:0] out_data_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [TOT_W-1:0] total_occ;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DROP_W-1:0] drop_q;

    tag_sync_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
      .clk   (clk_sample),
      .rst   (rst),
      .wr_en (tag_valid[c]),
      .din   (tag_in[c*TAG_W +: TAG_W]),
      .rd_en (pop[c]),
      .dout  (fifo_dout[c]),
      .full  (ch_full[c]),
      .empty (ch_empty[c]),
      .count (fifo_cnt[c])
    );

    // Clear outranks a coincident drop; the count sticks at its maximum.
    always_ff @(posedge clk_sample) begin
      if (!rst)                                                drop_q <= '0;
      else if (clear_drops)                                    drop_q <= '0;
      else if (tag_valid[c] && ch_full[c] && drop_q != DROP_MAX) drop_q <= drop_q + 1'b1;
    end

    assign drop_count[c*DROP_W +: DROP_W] = drop_q;
  end

  // Output handshake: a beat transfers on any edge where out_valid & out_ready;
  // the register reloads when empty or transferring and otherwise holds steady.
  assign load = ~out_valid_q | out_ready;

  always_comb begin
    int unsigned k;
    k         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      k = (int'(rr_q) + i) % N_CH;
      if (!gnt_found && !ch_empty[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(k);
      end
    end
  end

  assign rr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
  assign pop  = (load && gnt_found) ? (N_CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clk_sample) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_q        <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fifo_dout[gnt_idx];
        out_ch_q    <= gnt_idx;
        rr_q        <= rr_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    total_occ = '0;
    for (int c = 0; c < N_CH; c++) total_occ = total_occ + TOT_W'(fifo_cnt[c]);
  end

  assign almost_empty = (total_occ <= TOT_W'(AE_THRESH));
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ch       = out_ch_q;

endmodule

// File: tb/tb_phase_tag_merge_fifo.sv
// Directed and randomized checks of the merge FIFO against a queue-based model.
module tb_phase_tag_merge_fifo;
  import phase_tag_pkg::*;

  localparam int N_CH = 4, TAG_W = 8, DEPTH = 8, DROP_W = 8, AE_THRESH = 1, CH_W = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk_sample = 1'b0;
  logic                   rst;
  logic [N_CH*TAG_W-1:0]  tag_in;
  logic [N_CH-1:0]        tag_valid;
  logic [TAG_W-1:0]       out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_CH-1:0]        ch_full, ch_empty;
  logic [N_CH*DROP_W-1:0] drop_count;
  logic                   clear_drops;
  logic                   almost_empty;

  always #5 clk_sample = ~clk_sample;

  phase_tag_merge_fifo #(.N_CH(N_CH), .TAG_W(TAG_W), .DEPTH(DEPTH), .DROP_W(DROP_W),
                         .AE_THRESH(AE_THRESH)) dut (
    .clk_sample   (clk_sample),
    .rst          (rst),
    .tag_in       (tag_in),
    .tag_valid    (tag_valid),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ch_full      (ch_full),
    .ch_empty     (ch_empty),
    .drop_count   (drop_count),
    .clear_drops  (clear_drops),
    .almost_empty (almost_empty)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model + scoreboard ----------------
  int               n_tests = 0, n_fail = 0;
  logic [$bits(beat_t)-1:0] exp_q[$];
  logic [TAG_W-1:0] mq [N_CH][$];
  logic             m_valid = 1'b0;
  logic [TAG_W-1:0] m_data = '0;
  logic [CH_W-1:0]  m_ch = '0;
  int               m_rr = 0;
  int               m_drop [N_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one edge using the inputs the DUT sees at that edge.
  function automatic void model_update();
    bit   full_pre [N_CH];
    int   g, c;
    beat_t b;
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mq[i].delete();
        m_drop[i] = 0;
      end
      m_valid = 1'b0; m_data = '0; m_ch = '0; m_rr = 0;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < N_CH; i++) full_pre[i] = (mq[i].size() == DEPTH);
    if (!m_valid || out_ready) begin
      g = -1;
      for (int i = 0; i < N_CH; i++) begin
        c = (m_rr + i) % N_CH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g >= 0) begin
        m_data  = mq[g].pop_front();
        m_ch    = CH_W'(g);
        m_valid = 1'b1;
        m_rr    = (g + 1) % N_CH;
        b.ch = m_ch; b.tag = m_data;
        exp_q.push_back(b);
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (tag_valid[i]) begin
        if (full_pre[i]) begin
          if (m_drop[i] < (2**DROP_W) - 1) m_drop[i]++;
        end else begin
          mq[i].push_back(tag_in[i*TAG_W +: TAG_W]);
        end
      end
    end
    if (clear_drops) for (int i = 0; i < N_CH; i++) m_drop[i] = 0;
  endfunction

  function automatic bit model_busy();
    bit busy = m_valid;
    for (int i = 0; i < N_CH; i++) if (mq[i].size() > 0) busy = 1'b1;
    return busy;
  endfunction

  task automatic check_all();
    logic [N_CH-1:0]        e_empty, e_full;
    logic [N_CH*DROP_W-1:0] e_drop;
    int                     tot;
    tot = 0;
    for (int i = 0; i < N_CH; i++) begin
      e_empty[i] = (mq[i].size() == 0);
      e_full[i]  = (mq[i].size() == DEPTH);
      e_drop[i*DROP_W +: DROP_W] = DROP_W'(m_drop[i]);
      tot += mq[i].size();
    end
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_ch", out_ch, m_ch);
    end
    check("ch_empty", ch_empty, e_empty);
    check("ch_full", ch_full, e_full);
    check("almost_empty", almost_empty, tot <= AE_THRESH);
    check("drop_count", drop_count, e_drop);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (out_valid === 1'b1 && out_ready) begin
      check("beat_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("beat", {out_ch, out_data}, exp_q.pop_front());
    end
    @(posedge clk_sample);
    model_update();
    #1;
    check_all();
  endtask

  task automatic set_tag(input int c, input logic [TAG_W-1:0] v);
    tag_in[c*TAG_W +: TAG_W] = v;
    tag_valid[c] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tag_valid = '0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    tag_valid = '0; out_ready = 1'b1; clear_drops = 1'b0;
    while (model_busy() && k < 64) begin
      cycle();
      k++;
    end
    check("drain_done", model_busy(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [TAG_W-1:0] hd;
    logic [CH_W-1:0]  hc;
    int               ready_pct;
    rst = 1'b0; tag_in = '0; tag_valid = '0; out_ready = 1'b1; clear_drops = 1'b0;
    for (int i = 0; i < N_CH; i++) m_drop[i] = 0;

    // Reset holds off writes.
    for (int i = 0; i < 3; i++) begin
      tag_valid = N_CH'($urandom_range(0, 15));
      tag_in    = $urandom;
      cycle();
    end
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b1; tag_valid = '0;
    cycle();
    check("rst_no_output", out_valid, 0);

    // Single tag latency.
    tag_in = '0; set_tag(2, 8'h5A);
    cycle();
    tag_valid = '0;
    check("lat_edge_k", out_valid, 0);
    cycle();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h5A);
    check("lat_ch", out_ch, 2);
    cycle();
    check("lat_one_beat", out_valid, 0);

    // All channels at once, fresh pointer.
    do_reset();
    for (int c = 0; c < N_CH; c++) set_tag(c, TAG_W'(8'h10 + c));
    cycle();
    tag_valid = '0;
    for (int i = 0; i < N_CH; i++) begin
      cycle();
      check("rr_ch", out_ch, i);
      check("rr_data", out_data, 8'h10 + i);
    end
    cycle();
    check("rr_idle", out_valid, 0);
    check("rr_ae", almost_empty, 1);

    // Overflow on ch1, then a write while full coinciding with a pop.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tag_valid = '0; set_tag(1, TAG_W'(8'h20 + i));
      cycle();
    end
    tag_valid = '0;
    check("ovf_full", ch_full[1], 1);
    check("ovf_drops", drop_count[15:8], 3);
    out_ready = 1'b1; set_tag(1, 8'h77);
    cycle();
    check("ovf_pop_no_admit", drop_count[15:8], 4);
    drain();

    // Saturation and clear-beats-drop.
    out_ready = 1'b0; tag_valid = '0;
    for (int i = 0; i < 300; i++) begin
      set_tag(0, TAG_W'($urandom));
      cycle();
    end
    check("sat_drops", drop_count[7:0], 255);
    clear_drops = 1'b1; set_tag(0, 8'hEE);
    cycle();
    clear_drops = 1'b0; tag_valid = '0;
    check("clear_wins", drop_count, 0);
    drain();

    // Backpressure hold, then no bubbles.
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N_CH; c++) set_tag(c, TAG_W'($urandom));
      cycle();
    end
    tag_valid = '0;
    hd = m_data; hc = m_ch;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_data", out_data, hd);
      check("hold_ch", out_ch, hc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("no_bubble", out_valid, 1);
      cycle();
    end
    check("burst_done", out_valid, 0);

    // Reset mid-drain.
    out_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) set_tag(c, TAG_W'(8'h40 + c));
    cycle();
    tag_valid = '0; set_tag(1, 8'h44);
    cycle();
    tag_valid = '0; out_ready = 1'b1;
    cycle();
    rst = 1'b0; tag_valid = '1; tag_in = $urandom;
    cycle();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_empty", ch_empty, 4'hF);
    check("mid_rst_drops", drop_count, 0);
    rst = 1'b1; tag_valid = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_rst_quiet", out_valid, 0);
    end

    // Randomized traffic with varying consumer rate.
    ready_pct = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) ready_pct = $urandom_range(5, 100);
      tag_valid   = N_CH'($urandom_range(0, 15));
      tag_in      = $urandom;
      out_ready   = ($urandom_range(0, 99) < ready_pct);
      clear_drops = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 250) != 0);
      cycle();
    end
    rst = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_tag_merge_fifo.md
Name: phase_tag_merge_fifo

Overview:
Multi-channel successor to the single-detector phase-tag buffering stage. Accepts tag/valid pulses from N_CH phase detectors and buffers each channel in its own synchronous FIFO. A round-robin arbiter merges the channels into one valid/ready output stream tagged with the channel index. Per-channel drop counters record tags lost to overflow. The block sits in the clk_sample domain, between the detector array and the readout logic.

Parameters:
N_CH, 4, number of detector channels (≥2)
TAG_W, 8, phase tag width
DEPTH, 8, entries per channel FIFO (power of 2, ≥2)
DROP_W, 8, width of each saturating drop counter
AE_THRESH, 1, almost_empty asserts when total occupancy ≤ AE_THRESH
CH_W, $clog2(N_CH), derived; not overridable

Ports:
clk_sample  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
tag_in  in  N_CH*TAG_W  channel c tag at [c*TAG_W +: TAG_W]
tag_valid  in  N_CH  one-cycle write strobe per channel
out_data  out  TAG_W  merged tag
out_ch  out  CH_W  source channel of out_data
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  consumer accepts when out_valid & out_ready
ch_full  out  N_CH  per-channel FIFO full
ch_empty  out  N_CH  per-channel FIFO empty
drop_count  out  N_CH*DROP_W  per-channel saturating drop counts
clear_drops  in  1  synchronous clear of all drop counters
almost_empty  out  1  sum of FIFO occupancies ≤ AE_THRESH (output register excluded)

Behaviour:
- Reset (rst==0 at edge): all FIFOs emptied; out_valid=0, out_data=0, out_ch=0; drop_count=0; ch_empty all 1; ch_full all 0; almost_empty=1; RR pointer=0. tag_valid is ignored during reset. Reset mid-operation discards all buffered and in-flight tags without counting them as drops.
- Write: at an edge with tag_valid[c]=1 and ch_full[c]=0, tag is pushed. If ch_full[c]=1, the tag is discarded and drop_count[c] increments, saturating at 2^DROP_W-1. ch_full is evaluated on the pre-edge count: a pop from a full FIFO in the same cycle does NOT admit the write (drop is counted).
- Flags: ch_full/ch_empty/almost_empty are derived from registered occupancy counts (width $clog2(DEPTH+1)). No combinational path from tag_valid.
- Output register: loads when out_valid==0, or when out_valid & out_ready (back-to-back transfers with no bubble). While out_valid & !out_ready, out_data/out_ch are held stable.
- Arbiter: when load is allowed, grant the first non-empty channel scanning from RR pointer upward with wrap. The grant pops one entry into the output register, sets out_ch, and sets the pointer to (grant+1) mod N_CH. With no request, the pointer is unchanged and out_valid deasserts after a consumed beat.
- Latency: tag written at edge k into an empty channel with the output free → out_valid high after edge k+1.
- Per-channel order is preserved. Cross-channel fairness: with all channels backlogged, each channel gets exactly one grant per N_CH output beats.
- A channel written and popped in the same cycle keeps the same count. Pointers wrap modulo DEPTH.
- clear_drops: all counters go to 0. If a drop coincides with clear_drops, the clear wins and the counter becomes 0.

Decomposition:
- Package phase_tag_pkg:
  - TAG_W default
  - function clog2_safe
  - typedef for the {ch, tag} output beat struct
- Sub-module tag_sync_fifo: single-clock FIFO, parameters DEPTH and TAG_W; ports wr_en/din/rd_en/dout/full/empty/count; show-ahead dout. It is instantiated N_CH times via generate.
- Arbiter, output register and drop counters live in the top module.

Test Plan:
- Reset release, single tag 0x5A on ch2 at edge k, out_ready=1 → out_valid after edge k+1 with out_data=0x5A, out_ch=2; one beat only.
- All 4 channels write one tag in the same cycle (0x10, 0x11, 0x12, 0x13), out_ready=1 → beats on consecutive cycles in order ch0, ch1, ch2, ch3; then out_valid=0 and almost_empty=1.
- Fill ch1 with 8 tags (out_ready=0, output register holding first beat), then 3 more writes → ch_full[1]=1, drop_count[1]=3, buffered tags intact and FIFO order preserved on drain.
- 300 writes to full ch0 with DROP_W=8 → drop_count[0]=255 (saturated); clear_drops asserted together with a drop → 0.
- Hold out_ready=0 for 5 cycles with out_valid=1 → out_data/out_ch unchanged; then out_ready=1 continuously → no bubbles between beats.
- Assert rst=0 mid-drain with 5 tags buffered → next edge: out_valid=0, all ch_empty=1, drop_count unchanged at 0; tag_valid during reset produces no output afterward.
